// File: rtl/crack_pkg.sv
// Shared definitions for the key-search engine: FSM states, default printable
// range and the ciphertext address that holds the message length byte.
package crack_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARM,
    RUN,
    RD_LEN,
    GET_LEN,
    RD_PT,
    CHK,
    STEP,
    DONE
  } state_t;

  localparam logic [7:0] PRINT_LO_DEF = 8'h20;
  localparam logic [7:0] PRINT_HI_DEF = 8'h7E;
  localparam logic [7:0] LEN_ADDR     = 8'h00;

endpackage

// File: rtl/crack_chk.sv
// Per-byte verdict for one plaintext byte: inside the printable window, and
// whether the current index is the last byte of the message.
module crack_chk #(
  parameter logic [7:0] PRINT_LO = 8'h20,
  parameter logic [7:0] PRINT_HI = 8'h7E
) (
  input  logic [7:0] i_byte,
  input  logic [7:0] i_idx,
  input  logic [7:0] i_len,
  output logic       o_printable,
  output logic       o_last
);

  assign o_printable = (i_byte >= PRINT_LO) && (i_byte <= PRINT_HI);
  assign o_last      = (i_idx == i_len);

endmodule

// File: rtl/crack_n.sv
// Brute-force key search: steps through keys, lets an external arc4 core decrypt,
// and accepts the first key whose plaintext is entirely printable.
module crack_n
  import crack_pkg::*;
#(
  parameter int         KEY_W      = 24,
  parameter int         KEY_STRIDE = 1,
  parameter logic [7:0] PRINT_LO   = PRINT_LO_DEF,
  parameter logic [7:0] PRINT_HI   = PRINT_HI_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [KEY_W-1:0] key_start,
  input  logic             abort,
  output logic             rdy,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic [KEY_W-1:0] tried,
  output logic             arc4_en,
  input  logic             arc4_rdy,
  output logic [7:0]       ct_addr,
  input  logic [7:0]       ct_rddata,
  output logic [7:0]       pt_addr,
  input  logic [7:0]       pt_rddata
);

  state_t       r_state;
  logic         r_runFirst;
  logic [7:0]   r_len;
  logic [7:0]   r_idx;
  logic         w_printable;
  logic         w_last;
  logic [KEY_W:0] w_keyNext;

  crack_chk #(
    .PRINT_LO (PRINT_LO),
    .PRINT_HI (PRINT_HI)
  ) u_chk (
    .i_byte      (pt_rddata),
    .i_idx       (r_idx),
    .i_len       (r_len),
    .o_printable (w_printable),
    .o_last      (w_last)
  );

  // Extra top bit catches wrap-around, which means the key space is exhausted.
  assign w_keyNext = {1'b0, key} + (KEY_W+1)'(KEY_STRIDE);

  // The start pulse is suppressed when abort or reset would leave ARM this cycle.
  assign arc4_en = (r_state == ARM) && arc4_rdy && !abort && !rst;
  assign ct_addr = LEN_ADDR;
  assign pt_addr = (r_state == RD_PT) ? r_idx : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_runFirst <= 1'b0;
      r_len      <= 8'h00;
      r_idx      <= 8'h00;
      rdy        <= 1'b1;
      key        <= '0;
      key_valid  <= 1'b0;
      tried      <= '0;
    end else if (abort && (r_state != IDLE) && (r_state != DONE)) begin
      r_state   <= DONE;
      key_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            key       <= key_start;
            tried     <= '0;
            key_valid <= 1'b0;
            rdy       <= 1'b0;
            r_state   <= ARM;
          end
        end
        ARM: begin
          if (arc4_rdy) begin
            r_runFirst <= 1'b1;
            r_state    <= RUN;
          end
        end
        // The core's ready may still read high right after the start pulse.
        RUN: begin
          r_runFirst <= 1'b0;
          if (!r_runFirst && arc4_rdy) begin
            r_state <= RD_LEN;
          end
        end
        RD_LEN: begin
          r_state <= GET_LEN;
        end
        GET_LEN: begin
          r_len <= ct_rddata;
          r_idx <= 8'h01;
          if (ct_rddata == 8'h00) begin
            key_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_state <= RD_PT;
          end
        end
        RD_PT: begin
          r_state <= CHK;
        end
        CHK: begin
          if (!w_printable) begin
            r_state <= STEP;
          end else if (w_last) begin
            key_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_idx   <= r_idx + 8'h01;
            r_state <= RD_PT;
          end
        end
        STEP: begin
          tried <= tried + KEY_W'(1);
          if (w_keyNext[KEY_W]) begin
            r_state <= DONE;
          end else begin
            key     <= w_keyNext[KEY_W-1:0];
            r_state <= ARM;
          end
        end
        DONE: begin
          rdy     <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crack_n.sv
// Directed bench for crack_n: three instances (stride 1, stride 2, 4-bit key)
// sharing one behavioural arc4/RAM model whose plaintext depends on the key.
module tb_crack_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [7:0]  gLen, gGood1, gGood2, gBad;
  logic [23:0] gTarget;
  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] ptByte(input logic [23:0] k, input logic [7:0] a);
    if (k == gTarget) return (a == 8'd1) ? gGood1 : (a == 8'd2) ? gGood2 : 8'h00;
    return (a == 8'd1) ? gBad : 8'h00;
  endfunction

  logic        enA, abortA, rdyA, kvA, arcEnA, arcRdyA;
  logic [23:0] ksA, keyA, triedA;
  logic [7:0]  ctAddrA, ctDataA, ptAddrA, ptDataA;
  int          busyA = 0;
  int          ptReadsA = 0;
  logic [23:0] keyAtEnA = '0;

  logic        enB, abortB, rdyB, kvB, arcEnB, arcRdyB;
  logic [23:0] ksB, keyB, triedB;
  logic [7:0]  ctAddrB, ctDataB, ptAddrB, ptDataB;
  int          busyB = 0;
  int          key2CntB = 0;
  logic [23:0] keyAtEnB = '0;

  logic        enC, abortC, rdyC, kvC, arcEnC, arcRdyC;
  logic [3:0]  ksC, keyC, triedC;
  logic [7:0]  ctAddrC, ctDataC, ptAddrC, ptDataC;
  int          busyC = 0;
  logic [23:0] keyAtEnC = '0;

  assign arcRdyA = (busyA == 0);
  assign arcRdyB = (busyB == 0);
  assign arcRdyC = (busyC == 0);

  // arc4 model: busy for a few cycles after each start, RAMs with 1-cycle latency.
  always @(posedge clk) begin
    if (arcEnA) begin busyA <= 3; keyAtEnA <= keyA; end
    else if (busyA != 0) busyA <= busyA - 1;
    ctDataA <= (ctAddrA == 8'h00) ? gLen : 8'h00;
    ptDataA <= ptByte(keyAtEnA, ptAddrA);
    if (ptAddrA != 8'h00) ptReadsA <= ptReadsA + 1;
  end

  always @(posedge clk) begin
    if (arcEnB) begin busyB <= 3; keyAtEnB <= keyB; end
    else if (busyB != 0) busyB <= busyB - 1;
    ctDataB <= (ctAddrB == 8'h00) ? gLen : 8'h00;
    ptDataB <= ptByte(keyAtEnB, ptAddrB);
    if (keyB == 24'd2) key2CntB <= key2CntB + 1;
  end

  always @(posedge clk) begin
    if (arcEnC) begin busyC <= 3; keyAtEnC <= {20'h0, keyC}; end
    else if (busyC != 0) busyC <= busyC - 1;
    ctDataC <= (ctAddrC == 8'h00) ? gLen : 8'h00;
    ptDataC <= ptByte(keyAtEnC, ptAddrC);
  end

  crack_n #(.KEY_W(24), .KEY_STRIDE(1)) u_dutA (
    .clk(clk), .rst(rst), .en(enA), .key_start(ksA), .abort(abortA),
    .rdy(rdyA), .key(keyA), .key_valid(kvA), .tried(triedA),
    .arc4_en(arcEnA), .arc4_rdy(arcRdyA),
    .ct_addr(ctAddrA), .ct_rddata(ctDataA), .pt_addr(ptAddrA), .pt_rddata(ptDataA)
  );

  crack_n #(.KEY_W(24), .KEY_STRIDE(2)) u_dutB (
    .clk(clk), .rst(rst), .en(enB), .key_start(ksB), .abort(abortB),
    .rdy(rdyB), .key(keyB), .key_valid(kvB), .tried(triedB),
    .arc4_en(arcEnB), .arc4_rdy(arcRdyB),
    .ct_addr(ctAddrB), .ct_rddata(ctDataB), .pt_addr(ptAddrB), .pt_rddata(ptDataB)
  );

  crack_n #(.KEY_W(4), .KEY_STRIDE(1)) u_dutC (
    .clk(clk), .rst(rst), .en(enC), .key_start(ksC), .abort(abortC),
    .rdy(rdyC), .key(keyC), .key_valid(kvC), .tried(triedC),
    .arc4_en(arcEnC), .arc4_rdy(arcRdyC),
    .ct_addr(ctAddrC), .ct_rddata(ctDataC), .pt_addr(ptAddrC), .pt_rddata(ptDataC)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdyOf(input int inst);
    case (inst)
      0:       return rdyA;
      1:       return rdyB;
      default: return rdyC;
    endcase
  endfunction

  task automatic applyStimulus(input int inst, input logic [23:0] ks);
    @(negedge clk);
    case (inst)
      0:       begin enA = 1'b1; ksA = ks; end
      1:       begin enB = 1'b1; ksB = ks; end
      default: begin enC = 1'b1; ksC = ks[3:0]; end
    endcase
    @(negedge clk);
    enA = 1'b0;
    enB = 1'b0;
    enC = 1'b0;
  endtask

  task automatic waitIdle(input int inst, input string tag);
    int   cyc;
    logic r;
    cyc = 0;
    r   = rdyOf(inst);
    while (!r && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      r = rdyOf(inst);
    end
    checkOutput({tag, "_done"}, {31'd0, r}, 32'd1);
  endtask

  initial begin
    int s;
    int cyc;
    rst = 1'b1;
    enA = 1'b0; enB = 1'b0; enC = 1'b0;
    abortA = 1'b0; abortB = 1'b0; abortC = 1'b0;
    ksA = '0; ksB = '0; ksC = '0;
    gLen = 8'd2; gGood1 = 8'h48; gGood2 = 8'h69; gBad = 8'h01; gTarget = 24'd3;

    repeat (3) @(negedge clk);
    checkOutput("rst_rdy", {31'd0, rdyA}, 32'd1);
    checkOutput("rst_key", {8'd0, keyA}, 32'd0);
    checkOutput("rst_kv", {31'd0, kvA}, 32'd0);
    checkOutput("rst_tried", {8'd0, triedA}, 32'd0);
    checkOutput("rst_arc4en", {31'd0, arcEnA}, 32'd0);
    checkOutput("rst_ctaddr", {24'd0, ctAddrA}, 32'd0);
    checkOutput("rst_ptaddr", {24'd0, ptAddrA}, 32'd0);
    rst = 1'b0;

    // "Hi" appears only for key 3; keys 0..2 reject on their first byte.
    applyStimulus(0, 24'd0);
    checkOutput("t1_rdy_fall", {31'd0, rdyA}, 32'd0);
    waitIdle(0, "t1");
    checkOutput("t1_key", {8'd0, keyA}, 32'd3);
    checkOutput("t1_kv", {31'd0, kvA}, 32'd1);
    checkOutput("t1_tried", {8'd0, triedA}, 32'd3);

    s = key2CntB;
    applyStimulus(1, 24'd1);
    waitIdle(1, "t2");
    checkOutput("t2_key", {8'd0, keyB}, 32'd3);
    checkOutput("t2_kv", {31'd0, kvB}, 32'd1);
    checkOutput("t2_tried", {8'd0, triedB}, 32'd1);
    checkOutput("t2_key2_seen", key2CntB - s, 32'd0);

    gTarget = 24'h100;
    applyStimulus(2, 24'hE);
    waitIdle(2, "t3");
    checkOutput("t3_key", {28'd0, keyC}, 32'hF);
    checkOutput("t3_kv", {31'd0, kvC}, 32'd0);
    checkOutput("t3_tried", {28'd0, triedC}, 32'd2);
    checkOutput("t3_rdy", {31'd0, rdyC}, 32'd1);

    gBad = 8'h7F;
    applyStimulus(2, 24'hE);
    waitIdle(2, "t4");
    checkOutput("t4_7f_kv", {31'd0, kvC}, 32'd0);
    checkOutput("t4_7f_tried", {28'd0, triedC}, 32'd2);

    gTarget = 24'hE; gGood1 = 8'h7E; gGood2 = 8'h20;
    applyStimulus(2, 24'hE);
    waitIdle(2, "t5");
    checkOutput("t5_7e_key", {28'd0, keyC}, 32'hE);
    checkOutput("t5_7e_kv", {31'd0, kvC}, 32'd1);
    checkOutput("t5_7e_tried", {28'd0, triedC}, 32'd0);

    gLen = 8'd0; gTarget = 24'd3; gBad = 8'h01; gGood1 = 8'h48; gGood2 = 8'h69;
    s = ptReadsA;
    applyStimulus(0, 24'd5);
    waitIdle(0, "t6");
    checkOutput("t6_len0_key", {8'd0, keyA}, 32'd5);
    checkOutput("t6_len0_kv", {31'd0, kvA}, 32'd1);
    checkOutput("t6_len0_tried", {8'd0, triedA}, 32'd0);
    checkOutput("t6_len0_ptreads", ptReadsA - s, 32'd0);

    // Key 8 costs one read (0x1F rejected), key 9 reads both bytes.
    gLen = 8'd2; gBad = 8'h1F; gTarget = 24'd9;
    s = ptReadsA;
    applyStimulus(0, 24'd8);
    waitIdle(0, "t7");
    checkOutput("t7_key", {8'd0, keyA}, 32'd9);
    checkOutput("t7_kv", {31'd0, kvA}, 32'd1);
    checkOutput("t7_tried", {8'd0, triedA}, 32'd1);
    checkOutput("t7_ptreads", ptReadsA - s, 32'd3);

    gBad = 8'h01; gTarget = 24'd3;
    applyStimulus(0, 24'd0);
    cyc = 0;
    while (!arcEnA && cyc < 100) begin @(negedge clk); cyc++; end
    checkOutput("t8_arm_pulse", {31'd0, arcEnA}, 32'd1);
    @(negedge clk);
    abortA = 1'b1;
    @(negedge clk);
    abortA = 1'b0;
    checkOutput("t8_abort_kv", {31'd0, kvA}, 32'd0);
    checkOutput("t8_abort_done_rdy", {31'd0, rdyA}, 32'd0);
    @(negedge clk);
    checkOutput("t8_abort_idle_rdy", {31'd0, rdyA}, 32'd1);
    checkOutput("t8_abort_tried", {8'd0, triedA}, 32'd0);
    applyStimulus(0, 24'd0);
    waitIdle(0, "t9");
    checkOutput("t9_key", {8'd0, keyA}, 32'd3);
    checkOutput("t9_kv", {31'd0, kvA}, 32'd1);
    checkOutput("t9_tried", {8'd0, triedA}, 32'd3);

    gTarget = 24'd7;
    applyStimulus(0, 24'd5);
    cyc = 0;
    while (ptAddrA == 8'h00 && cyc < 100) begin @(negedge clk); cyc++; end
    checkOutput("t10_rdpt_seen", {24'd0, ptAddrA}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t10_rst_rdy", {31'd0, rdyA}, 32'd1);
    checkOutput("t10_rst_key", {8'd0, keyA}, 32'd0);
    checkOutput("t10_rst_kv", {31'd0, kvA}, 32'd0);
    checkOutput("t10_rst_tried", {8'd0, triedA}, 32'd0);
    checkOutput("t10_rst_ptaddr", {24'd0, ptAddrA}, 32'd0);
    rst = 1'b0;
    gTarget = 24'd3;
    applyStimulus(0, 24'd0);
    waitIdle(0, "t11");
    checkOutput("t11_key", {8'd0, keyA}, 32'd3);
    checkOutput("t11_kv", {31'd0, kvA}, 32'd1);
    checkOutput("t11_tried", {8'd0, triedA}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crack_n.md
CRACK_N -- requirements
Module: crack_n

Interface
REQ-001 Parameter KEY_W, default 24: key width in bits.
REQ-002 Parameter KEY_STRIDE, default 1: key increment per attempt; a value of 2 gives an odd/even core split.
REQ-003 Parameter PRINT_LO / PRINT_HI, default 8'h20 / 8'h7E: inclusive printable byte range.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  start request; sampled only while rdy=1.
REQ-007 key_start  in  KEY_W  first key tried; sampled with en.
REQ-008 abort  in  1  terminate the current search.
REQ-009 rdy  out  1  idle, ready to accept en.
REQ-010 key  out  KEY_W  key under test; the found key when key_valid=1.
REQ-011 key_valid  out  1  last search found a printable key.
REQ-012 tried  out  KEY_W  count of keys fully rejected in the current search.
REQ-013 arc4_en / arc4_rdy  out / in  1 / 1  handshake to the external arc4 core, which decrypts ct to pt using key.
REQ-014 ct_addr / ct_rddata  out / in  8 / 8  ciphertext RAM read port, 1-cycle latency.
REQ-015 pt_addr / pt_rddata  out / in  8 / 8  plaintext RAM read port, 1-cycle latency.

Function
REQ-016 FSM states: IDLE, ARM, RUN, RD_LEN, GET_LEN, RD_PT, CHK, STEP, DONE.
REQ-017 IDLE: rdy=1; on en, latch key=key_start, tried=0, key_valid=0; next state ARM; rdy falls the next cycle.
REQ-018 ARM: hold until arc4_rdy=1; then drive arc4_en=1 for exactly one cycle; next state RUN.
REQ-019 RUN: ignore arc4_rdy in the first cycle; on later arc4_rdy=1, go to RD_LEN.
REQ-020 RD_LEN: ct_addr=0; GET_LEN captures L=ct_rddata one cycle later; index i=1.
REQ-021 L=0: key accepted immediately; DONE with key_valid=1.
REQ-022 RD_PT drives pt_addr=i; CHK evaluates pt_rddata one cycle later.
REQ-023 CHK: byte out of [PRINT_LO,PRINT_HI] -> STEP at once (early reject); in range with i=L -> DONE, key_valid=1; otherwise i+=1, back to RD_PT.
REQ-024 STEP: tried+=1; compute key+KEY_STRIDE at KEY_W+1 bits; carry set -> DONE, key_valid=0 (exhausted), key unchanged; else key+=KEY_STRIDE, back to ARM.
REQ-025 abort=1 in any state except IDLE and DONE -> DONE next cycle, key_valid=0, arc4_en=0; the arc4 core may still be running, and ARM of the next search waits for arc4_rdy.
REQ-026 DONE: one cycle; then IDLE with rdy=1; key, key_valid and tried hold until the next accepted en.
REQ-027 en outside IDLE is ignored; abort in IDLE/DONE is ignored.
REQ-028 Address outputs are 0 in every state that does not read.
REQ-029 arc4_en is 0 outside its ARM cycle.
REQ-030 All outputs are registered, except address outputs and arc4_en, which are decoded from state.
REQ-031 Minimum per-key latency: ARM→RUN overhead plus 2 cycles per checked byte plus 3 cycles (RD_LEN, GET_LEN, STEP).

Reset
REQ-032 rst=1 at a clock edge forces IDLE next cycle from any state, including mid-search.
REQ-033 Reset values: rdy=1, key=0, key_valid=0, tried=0, arc4_en=0, ct_addr=0, pt_addr=0.

Structure
REQ-034 Package crack_pkg holds: state enum, default PRINT_LO/PRINT_HI, and the length-byte address constant (0).
REQ-035 One sub-module, crack_chk: combinational printable-range compare plus the i=L terminal test, shared with future multi-core wrappers.
REQ-036 The arc4 core and both RAMs stay outside the block.

Verification
REQ-037 key_start=0, stride 1, arc4 model decrypts to "Hi" only for key 24'h000003 -> key=3, key_valid=1, tried=3.
REQ-038 Stride 2, key_start=1, same target -> key=3, key_valid=1, tried=1; key 2 is never driven.
REQ-039 KEY_W=4, key_start=4'hE, stride 1, no valid key -> key=4'hF, key_valid=0, tried=2, rdy=1.
REQ-040 L=0 -> key_valid=1 on the first key; no pt_addr read occurs.
REQ-041 First byte 8'h1F for a wrong key -> exactly one pt read before STEP; byte 8'h7F rejected, 8'h7E accepted.
REQ-042 abort asserted in RUN -> DONE next cycle, key_valid=0; rst asserted mid-CHK -> IDLE next cycle with reset values; a new en then completes correctly.
